// File: rtl/result_rf_sequencer_if.sv
// ----------------------------------------------------------------------------
// result_rf_sequencer_if
//
// Purpose:
//   Bundles the conv-value input stream and the result register-file control
//   bus that the result_rf_sequencer drives.
//
// Parameters:
//   ADDR_W       width of the register-file word address
//
// Signals:
//   in_valid     conv value available (producer -> sequencer)
//   in_ready     sequencer accepts in_value this cycle
//   in_value     8-bit conv partial result
//   store        register-file store strobe
//   pool         register-file pool strobe
//   cout_done    register-file dump strobe
//   first_write  qualifies store as a clear write
//   out_c        target channel bank
//   addr         target word address
//   bias         bias table entry for current out_c
//   value        data for the store
//
// Modports:
//   master       sequencer side (accepts the stream, drives the RF bus)
//   slave        producer / register-file side
// ----------------------------------------------------------------------------
interface result_rf_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_value;
    logic              store;
    logic              pool;
    logic              cout_done;
    logic              first_write;
    logic [3:0]        out_c;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        bias;
    logic [7:0]        value;

    modport master (
        input  in_valid, in_value,
        output in_ready, store, pool, cout_done, first_write,
               out_c, addr, bias, value
    );

    modport slave (
        output in_valid, in_value,
        input  in_ready, store, pool, cout_done, first_write,
               out_c, addr, bias, value
    );
endinterface

// File: rtl/result_rf_sequencer.sv
// ----------------------------------------------------------------------------
// result_rf_sequencer
//
// Purpose:
//   Control FSM for the conv-layer result register file. For every output
//   channel it clears the bank (first_write stores), then streams accepted
//   conv values into it once per input pass. After the last channel it runs
//   one max-pool sweep over all banks and emits a single cout_done pulse.
//   Holds the per-channel bias table, presented alongside every store.
//
// Configuration:
//   RESULT_SEQ_POOL_EN  when defined, the POOL sweep is present; when not
//                       defined, pool is tied low and the last accumulate
//                       beat goes straight to the dump.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active-high
//   i_start       begin a layer (sampled only in IDLE)
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse when the layer completes
//   i_bias_we     bias table write strobe (honoured only when idle)
//   i_bias_waddr  bias table index
//   i_bias_wdata  bias value
//   rfBus         stream + register-file bus (master modport)
// ----------------------------------------------------------------------------
module result_rf_sequencer #(
    parameter int NUM_OUT_CH   = 8,
    parameter int CHANNEL_SIZE = 784,
    parameter int NUM_IN_CH    = 1,
    parameter int ADDR_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic                 i_bias_we,
    input  logic [2:0]           i_bias_waddr,
    input  logic [7:0]           i_bias_wdata,
    result_rf_sequencer_if.master rfBus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHANNEL_SIZE - 1);
    localparam logic [3:0]        LAST_CH   = 4'(NUM_OUT_CH - 1);
    localparam logic [3:0]        LAST_PASS = 4'(NUM_IN_CH - 1);
`ifdef RESULT_SEQ_POOL_EN
    localparam logic [ADDR_W-1:0] LAST_POOL = ADDR_W'(CHANNEL_SIZE - 4);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
`ifdef RESULT_SEQ_POOL_EN
        S_POOL,
`endif
        S_DUMP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_ch;
    logic [3:0]        r_pass;
    logic [ADDR_W-1:0] r_addrCnt;
    logic [7:0]        r_biasTable [8];

    logic              r_store;
    logic              r_coutDone;
    logic              r_firstWrite;
    logic [3:0]        r_outC;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_bias;
    logic [7:0]        r_value;
`ifdef RESULT_SEQ_POOL_EN
    logic              r_pool;
`endif

    logic w_inReady;
    logic w_biasWrite;

    // The sequencer only ever takes beats while accumulating, so ready is a
    // pure decode of the state register; it falls the cycle after the final
    // beat because that beat moves the FSM out of ACCUM.
    assign w_inReady   = (r_state == S_ACCUM);
    // Indices past the last sequenced channel are silently dropped.
    assign w_biasWrite = i_bias_we && (r_state == S_IDLE) &&
                         ({1'b0, i_bias_waddr} < 4'(NUM_OUT_CH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_pass       <= '0;
            r_addrCnt    <= '0;
            r_store      <= 1'b0;
            r_coutDone   <= 1'b0;
            r_firstWrite <= 1'b0;
            r_outC       <= '0;
            r_addr       <= '0;
            r_bias       <= '0;
            r_value      <= '0;
`ifdef RESULT_SEQ_POOL_EN
            r_pool       <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                r_biasTable[i] <= '0;
            end
        end else begin
            // Strobes are single-cycle unless the current state re-asserts them.
            r_store    <= 1'b0;
            r_coutDone <= 1'b0;
`ifdef RESULT_SEQ_POOL_EN
            r_pool     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_biasWrite) begin
                        r_biasTable[i_bias_waddr] <= i_bias_wdata;
                    end
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_ch      <= '0;
                        r_pass    <= '0;
                        r_addrCnt <= '0;
                    end
                end

                S_CLEAR: begin
                    r_store      <= 1'b1;
                    r_firstWrite <= 1'b1;
                    r_value      <= '0;
                    r_outC       <= r_ch;
                    r_addr       <= r_addrCnt;
                    r_bias       <= r_biasTable[r_ch[2:0]];
                    if (r_addrCnt == LAST_ADDR) begin
                        r_addrCnt <= '0;
                        r_state   <= S_ACCUM;
                    end else begin
                        r_addrCnt <= r_addrCnt + ADDR_W'(1);
                    end
                end

                S_ACCUM: begin
                    if (rfBus.in_valid) begin
                        r_store      <= 1'b1;
                        r_firstWrite <= 1'b0;
                        r_value      <= rfBus.in_value;
                        r_outC       <= r_ch;
                        r_addr       <= r_addrCnt;
                        r_bias       <= r_biasTable[r_ch[2:0]];
                        if (r_addrCnt == LAST_ADDR) begin
                            r_addrCnt <= '0;
                            if (r_pass == LAST_PASS) begin
                                r_pass <= '0;
                                if (r_ch == LAST_CH) begin
                                    r_ch <= '0;
`ifdef RESULT_SEQ_POOL_EN
                                    r_state <= S_POOL;
`else
                                    r_state <= S_DUMP;
`endif
                                end else begin
                                    r_ch    <= r_ch + 4'd1;
                                    r_state <= S_CLEAR;
                                end
                            end else begin
                                r_pass <= r_pass + 4'd1;
                            end
                        end else begin
                            r_addrCnt <= r_addrCnt + ADDR_W'(1);
                        end
                    end
                end

`ifdef RESULT_SEQ_POOL_EN
                // Pool works on groups of four words across every bank at
                // once, so out_c is parked at 0 for the whole sweep.
                S_POOL: begin
                    r_pool       <= 1'b1;
                    r_firstWrite <= 1'b0;
                    r_outC       <= '0;
                    r_addr       <= r_addrCnt;
                    r_bias       <= r_biasTable[0];
                    if (r_addrCnt == LAST_POOL) begin
                        r_addrCnt <= '0;
                        r_state   <= S_DUMP;
                    end else begin
                        r_addrCnt <= r_addrCnt + ADDR_W'(4);
                    end
                end
`endif

                S_DUMP: begin
                    r_coutDone   <= 1'b1;
                    r_firstWrite <= 1'b0;
                    r_state      <= S_DONE;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

    assign rfBus.in_ready    = w_inReady;
    assign rfBus.store       = r_store;
    assign rfBus.cout_done   = r_coutDone;
    assign rfBus.first_write = r_firstWrite;
    assign rfBus.out_c       = r_outC;
    assign rfBus.addr        = r_addr;
    assign rfBus.bias        = r_bias;
    assign rfBus.value       = r_value;
`ifdef RESULT_SEQ_POOL_EN
    assign rfBus.pool        = r_pool;
`else
    assign rfBus.pool        = 1'b0;
`endif

endmodule

// File: tb/tb_result_rf_sequencer.sv
// ----------------------------------------------------------------------------
// tb_result_rf_sequencer
//
// Purpose:
//   Scoreboard bench for result_rf_sequencer with a small layer
//   (2 output channels, 8-word banks, 2 input passes). Each layer's full
//   sequence of register-file events is generated from the layer rules when
//   start is issued; accepted conv beats are queued separately and fill in
//   the value of each accumulate store. A monitor pops and compares on every
//   store/pool/cout_done cycle. Honours RESULT_SEQ_POOL_EN like the design.
// ----------------------------------------------------------------------------
module tb_result_rf_sequencer;

    localparam int NOC = 2;
    localparam int CS  = 8;
    localparam int NIC = 2;
    localparam int AW  = 4;
`ifdef RESULT_SEQ_POOL_EN
    localparam int EXP_CYCLES = NOC * (1 + NIC) * CS + CS / 4 + 2;
`else
    localparam int EXP_CYCLES = NOC * (1 + NIC) * CS + 2;
`endif

    localparam logic [2:0] K_STORE = 3'b100;
    localparam logic [2:0] K_POOL  = 3'b010;
    localparam logic [2:0] K_DUMP  = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic       fw;
        logic [3:0] outC;
        logic [9:0] addr;
        logic [7:0] bias;
        logic [7:0] value;
    } evt_t;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       o_busy;
    logic       o_done;
    logic       i_bias_we;
    logic [2:0] i_bias_waddr;
    logic [7:0] i_bias_wdata;

    result_rf_sequencer_if #(.ADDR_W(AW)) rfBus ();

    result_rf_sequencer #(
        .NUM_OUT_CH  (NOC),
        .CHANNEL_SIZE(CS),
        .NUM_IN_CH   (NIC),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .i_bias_we   (i_bias_we),
        .i_bias_waddr(i_bias_waddr),
        .i_bias_wdata(i_bias_wdata),
        .rfBus       (rfBus)
    );

    int         nChecks = 0;
    int         nFails  = 0;
    int         validMode = 3;
    logic [7:0] tbl [8];
    evt_t       expQ[$];
    logic [7:0] acceptQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Producer: 0 = held high, 1 = random, 2 = toggling, 3 = idle low.
    always @(negedge clk) begin
        case (validMode)
            0:       rfBus.in_valid = 1'b1;
            1:       rfBus.in_valid = 1'($urandom_range(0, 1));
            2:       rfBus.in_valid = ~rfBus.in_valid;
            default: rfBus.in_valid = 1'b0;
        endcase
        rfBus.in_value = 8'($urandom);
    end

    // Every accepted beat must appear as the next accumulate store's value.
    always @(posedge clk) begin
        if (!rst && rfBus.in_valid && rfBus.in_ready) begin
            acceptQ.push_back(rfBus.in_value);
        end
    end

    // Monitor: pops one expected event per register-file strobe cycle.
    always @(negedge clk) begin
        evt_t actEv;
        evt_t expEv;
        if (!rst && (rfBus.store || rfBus.pool || rfBus.cout_done)) begin
            actEv.kind  = {rfBus.store, rfBus.pool, rfBus.cout_done};
            actEv.fw    = rfBus.first_write;
            actEv.outC  = rfBus.out_c;
            actEv.addr  = 10'(rfBus.addr);
            actEv.bias  = rfBus.bias;
            actEv.value = rfBus.value;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedStrobe", 64'(actEv), 64'd0);
            end else begin
                expEv = expQ.pop_front();
                if (expEv.kind == K_STORE && !expEv.fw) begin
                    if (acceptQ.size() == 0) begin
                        checkOutput("storeWithoutBeat", 64'(acceptQ.size()), 64'd1);
                    end else begin
                        expEv.value = acceptQ.pop_front();
                    end
                end
                if (expEv.kind != K_STORE) begin
                    actEv.fw    = 1'b0;
                    actEv.bias  = '0;
                    actEv.value = '0;
                end
                if (expEv.kind == K_DUMP) begin
                    actEv.outC = '0;
                    actEv.addr = '0;
                end
                checkOutput("rfEvent", 64'(actEv), 64'(expEv));
            end
        end
    end

    task automatic buildExpected();
        evt_t e;
        for (int c = 0; c < NOC; c++) begin
            for (int w = 0; w < (1 + NIC) * CS; w++) begin
                e.kind  = K_STORE;
                e.fw    = (w < CS);
                e.outC  = 4'(c);
                e.addr  = 10'(w % CS);
                e.bias  = tbl[c];
                e.value = '0;
                expQ.push_back(e);
            end
        end
`ifdef RESULT_SEQ_POOL_EN
        for (int w = 0; w < CS; w += 4) begin
            e = '0;
            e.kind = K_POOL;
            e.addr = 10'(w);
            expQ.push_back(e);
        end
`endif
        e = '0;
        e.kind = K_DUMP;
        expQ.push_back(e);
    endtask

    // One bias-table write; the model only follows it while idle and in range.
    task automatic applyStimulus(input logic [2:0] wa, input logic [7:0] wd);
        @(negedge clk);
        i_bias_we    = 1'b1;
        i_bias_waddr = wa;
        i_bias_wdata = wd;
        if (int'(wa) < NOC) tbl[wa] = wd;
        @(negedge clk);
        i_bias_we = 1'b0;
    endtask

    // Runs one layer. pokeBusy issues a start and a bias write mid-ACCUM;
    // resetAt > 0 aborts the layer with rst at that cycle.
    task automatic runLayer(input int mode, input bit pokeBusy, input int resetAt);
        int n;
        bit seen;
        validMode = mode;
        buildExpected();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("busyAfterStart", 64'(o_busy), 64'd1);
        n = 1;
        seen = 1'b0;
        while (n < 3000 && !seen) begin
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (resetAt > 0 && n == resetAt) begin
                    rst = 1'b1;
                    @(negedge clk);
                    checkOutput("afterReset", 64'({o_busy, rfBus.store, rfBus.in_ready}), 64'd0);
                    expQ.delete();
                    acceptQ.delete();
                    for (int i = 0; i < 8; i++) tbl[i] = '0;
                    rst = 1'b0;
                    return;
                end
                if (pokeBusy && n == 12) begin
                    i_start      = 1'b1;
                    i_bias_we    = 1'b1;
                    i_bias_waddr = 3'd1;
                    i_bias_wdata = 8'h7F;
                end else begin
                    i_start   = 1'b0;
                    i_bias_we = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        i_start   = 1'b0;
        i_bias_we = 1'b0;
        checkOutput("doneSeen", 64'(seen), 64'd1);
        if (mode == 0) checkOutput("doneLatency", 64'(n), 64'(EXP_CYCLES));
        @(negedge clk);
        checkOutput("donePulse", 64'({o_done, o_busy}), 64'd0);
        checkOutput("drained", 64'(expQ.size() + acceptQ.size()), 64'd0);
        expQ.delete();
        acceptQ.delete();
    endtask

    initial begin
        rst            = 1'b1;
        i_start        = 1'b0;
        i_bias_we      = 1'b0;
        i_bias_waddr   = '0;
        i_bias_wdata   = '0;
        rfBus.in_valid = 1'b0;
        rfBus.in_value = '0;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetState",
            64'({o_busy, o_done, rfBus.in_ready, rfBus.store, rfBus.pool, rfBus.cout_done,
                 rfBus.first_write, rfBus.out_c, rfBus.addr, rfBus.bias, rfBus.value}), 64'd0);

        applyStimulus(3'd0, 8'h05);
        applyStimulus(3'd1, 8'h11);
        applyStimulus(3'd7, 8'h33);
        $display("[TB] full layer, in_valid held high, busy pokes");
        runLayer(0, 1'b1, 0);

        $display("[TB] back-pressure layer, in_valid toggling");
        runLayer(2, 1'b0, 0);

        for (int r = 0; r < 2; r++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
            $display("[TB] random in_valid layer %0d", r);
            runLayer(1, 1'b0, 0);
        end

        $display("[TB] reset mid-ACCUM then fresh layer");
        runLayer(0, 1'b0, 12);
        runLayer(0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
